// File: rtl/mem_burst_sequencer_if.sv
// Purpose : bundles the request, cache-data and memory-side signals of the line-transfer engine.
// Latency : none; the interface carries wires only.
// Backpressure : the requester holds req_rd/req_wr until done, and mem_busy stalls individual banks.
// Ports   : master = cache controller / memory side, slave = mem_burst_sequencer.
interface mem_burst_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  // request side
  logic              req_rd;
  logic              req_wr;
  logic [ADDR_W-4:0] victim_addr;
  logic [ADDR_W-4:0] fill_addr;
  logic              req_ready;
  logic              done;
  logic              err;
  // cache data array side
  logic [DATA_W-1:0] wb_data_in;
  logic [2:0]        cache_offset;
  logic              fill_we;
  logic [2:0]        fill_offset;
  logic [DATA_W-1:0] fill_data;
  // memory side
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_out;
  logic [DATA_W-1:0] mem_data_in;
  logic [3:0]        mem_busy;
  logic              mem_err;

  modport master (
    output req_rd, req_wr, victim_addr, fill_addr, wb_data_in, mem_data_in, mem_busy, mem_err,
    input  req_ready, done, err, cache_offset, fill_we, fill_offset, fill_data,
           mem_rd, mem_wr, mem_addr, mem_data_out
  );

  modport slave (
    input  req_rd, req_wr, victim_addr, fill_addr, wb_data_in, mem_data_in, mem_busy, mem_err,
    output req_ready, done, err, cache_offset, fill_we, fill_offset, fill_data,
           mem_rd, mem_wr, mem_addr, mem_data_out
  );
endinterface

// File: rtl/mem_burst_sequencer.sv
// Purpose : 4-word victim write-back and/or 4-word line fill between the cache and banked memory.
// Latency : first strobe the cycle after accept, one word per cycle; done 1 cycle after the last
//           write (write-back only) or RD_LAT+1 cycles after the last read issue.
// Backpressure : a busy bank stalls the sequence with no strobe; requests are ignored unless idle.
// Ports   : clk, rst_n (async, active-low); bus = slave side of mem_burst_sequencer_if.
module mem_burst_sequencer #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  mem_burst_sequencer_if.slave bus
);
  localparam int LINE_W = ADDR_W - 3;

  typedef enum logic [2:0] {S_IDLE, S_WB, S_FILL, S_DRAIN, S_DONE} state_e;

  state_e                       state_q, state_d;
  logic [1:0]                   cnt_q, cnt_d;
  logic [LINE_W-1:0]            vic_q, vic_d;
  logic [LINE_W-1:0]            fil_q, fil_d;
  logic                         fill_pend_q, fill_pend_d;
  logic                         err_q, err_d;
  // return pipe: valid bit and word index per stage, oldest entry at RD_LAT-1
  logic [RD_LAT-1:0]            rv_q, rv_d;
  logic [RD_LAT-1:0][1:0]       ro_q, ro_d;

  logic                         accept, push, upstream_busy, bank_busy, ret_vld;
  logic                         rd_s, wr_s, done_s, err_s, rdy_s;
  logic [ADDR_W-1:0]            addr_s;

  assign bank_busy = bus.mem_busy[cnt_q];
  assign ret_vld   = rv_q[RD_LAT-1];

  // Entries still travelling through the pipe, excluding the one leaving this cycle.
  always_comb begin
    upstream_busy = 1'b0;
    for (int i = 0; i < RD_LAT - 1; i++) upstream_busy = upstream_busy | rv_q[i];
  end

  always_comb begin
    rv_d[0] = push;
    ro_d[0] = cnt_q;
    for (int i = 1; i < RD_LAT; i++) begin
      rv_d[i] = rv_q[i-1];
      ro_d[i] = ro_q[i-1];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    vic_d       = vic_q;
    fil_d       = fil_q;
    fill_pend_d = fill_pend_q;
    err_d       = err_q;
    accept      = 1'b0;
    push        = 1'b0;
    rd_s        = 1'b0;
    wr_s        = 1'b0;
    done_s      = 1'b0;
    err_s       = 1'b0;
    rdy_s       = 1'b0;
    addr_s      = '0;
    case (state_q)
      S_IDLE: begin
        rdy_s = 1'b1;
        if (bus.req_rd || bus.req_wr) begin
          accept      = 1'b1;
          vic_d       = bus.victim_addr;
          fil_d       = bus.fill_addr;
          cnt_d       = 2'd0;
          fill_pend_d = bus.req_rd;
          state_d     = bus.req_wr ? S_WB : S_FILL;
        end
      end
      S_WB: begin
        addr_s = {vic_q, cnt_q, 1'b0};
        if (!bank_busy) begin
          wr_s  = 1'b1;
          cnt_d = cnt_q + 2'd1;  // wraps to 0 exactly as the line completes
          if (cnt_q == 2'd3) state_d = fill_pend_q ? S_FILL : S_DONE;
        end
      end
      S_FILL: begin
        addr_s = {fil_q, cnt_q, 1'b0};
        if (!bank_busy) begin
          rd_s  = 1'b1;
          push  = 1'b1;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!upstream_busy) state_d = S_DONE;
      end
      S_DONE: begin
        done_s  = 1'b1;
        err_s   = err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Sticky error covers every memory beat of the request; the transfer itself never aborts.
    if (accept) err_d = 1'b0;
    else if (bus.mem_err && (rd_s || wr_s || ret_vld)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 2'd0;
      vic_q       <= '0;
      fil_q       <= '0;
      fill_pend_q <= 1'b0;
      err_q       <= 1'b0;
      rv_q        <= '0;
      ro_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vic_q       <= vic_d;
      fil_q       <= fil_d;
      fill_pend_q <= fill_pend_d;
      err_q       <= err_d;
      rv_q        <= rv_d;
      ro_q        <= ro_d;
    end
  end

  assign bus.req_ready    = rdy_s;
  assign bus.mem_rd       = rd_s;
  assign bus.mem_wr       = wr_s;
  assign bus.mem_addr     = addr_s;
  assign bus.mem_data_out = wr_s ? bus.wb_data_in : {DATA_W{1'b0}};
  assign bus.cache_offset = {cnt_q, 1'b0};
  assign bus.fill_we      = ret_vld;
  assign bus.fill_offset  = ret_vld ? {ro_q[RD_LAT-1], 1'b0} : 3'd0;
  assign bus.fill_data    = bus.mem_data_in;
  assign bus.done         = done_s;
  assign bus.err          = err_s;
endmodule

// File: tb/tb_mem_burst_sequencer.sv
`timescale 1ns/1ps
module tb_mem_burst_sequencer;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int RD_LAT = 2;

  typedef struct packed {
    logic        rdy;
    logic        wr;
    logic        rd;
    logic [15:0] addr;
    logic [15:0] wdat;
    logic [2:0]  coff;
    logic        fwe;
    logic [2:0]  foff;
    logic [15:0] fdat;
    logic        done;
    logic        err;
  } out_t;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [12:0] va;
    logic [12:0] fa;
    logic [15:0] base;
    int          bbank;
    int          bfrom;
    int          blen;
    int          err_at;
    int          exp_done;
    bit          exp_err;
    logic [15:0] exp_addr0;
  } vec_t;

  logic clk;
  logic rst_n;

  mem_burst_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_burst_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cache data array: combinational read at cache_offset
  logic [15:0] wbw [4];
  assign bus.wb_data_in = wbw[bus.cache_offset[2:1]];

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          cur_rd, cur_wr, cur_err;
  logic [12:0] cur_va, cur_fa;
  logic [3:0]  cur_busy;
  logic [15:0] cur_base;
  logic        hv [RD_LAT];
  logic [15:0] ha [RD_LAT];
  logic [3:0]  bt [64];
  bit          et [64];

  function automatic out_t grab();
    out_t o;
    o.rdy  = bus.req_ready;
    o.wr   = bus.mem_wr;
    o.rd   = bus.mem_rd;
    o.addr = bus.mem_addr;
    o.wdat = bus.mem_data_out;
    o.coff = bus.cache_offset;
    o.fwe  = bus.fill_we;
    o.foff = bus.fill_offset;
    o.fdat = bus.fill_data;
    o.done = bus.done;
    o.err  = bus.err;
    return o;
  endfunction

  // fields that carry meaning only alongside their strobe
  function automatic out_t msk(out_t o);
    out_t m = o;
    if (!m.wr && !m.rd) m.addr = '0;
    if (!m.wr) begin m.wdat = '0; m.coff = '0; end
    if (!m.fwe) begin m.foff = '0; m.fdat = '0; end
    return m;
  endfunction

  function automatic out_t rst_view(out_t o);
    out_t m = o;
    m.wdat = '0;
    m.fdat = '0;
    return m;
  endfunction

  task automatic check(input string name, input int idx, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h required %h", name, idx, got, exp);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, sample late in the cycle,
  // then record this cycle's read issue for the memory return model.
  task automatic tick(output out_t o);
    @(posedge clk);
    #1;
    bus.req_rd      = cur_rd;
    bus.req_wr      = cur_wr;
    bus.victim_addr = cur_va;
    bus.fill_addr   = cur_fa;
    bus.mem_busy    = cur_busy;
    bus.mem_err     = cur_err;
    bus.mem_data_in = hv[RD_LAT-1] ? cur_base + {13'd0, ha[RD_LAT-1][2:0]} : 16'h0BAD;
    #3;
    o = grab();
    for (int i = RD_LAT - 1; i > 0; i--) begin
      hv[i] = hv[i-1];
      ha[i] = ha[i-1];
    end
    hv[0] = bus.mem_rd;
    ha[0] = bus.mem_addr;
  endtask

  // Runs one request from its accept cycle (rel 0) to the cycle after done, comparing every
  // cycle against a schedule built from the word list and the busy/error traces.
  task automatic run_txn(input vec_t v, input bit rnd, output int got_done, output logic got_err,
                         output logic [15:0] got_addr0);
    out_t        ev [64];
    out_t        o;
    int          c, last, dn, nw;
    bit          e, seen;
    logic [1:0]  kk;
    for (int i = 0; i < 64; i++) begin bt[i] = 4'd0; et[i] = 1'b0; ev[i] = '0; end
    if (rnd) begin
      for (int i = 1; i < 40; i++) begin
        for (int b = 0; b < 4; b++) bt[i][b] = ($urandom_range(0, 3) == 0);
        et[i] = ($urandom_range(0, 15) == 0);
      end
    end else begin
      for (int i = v.bfrom; i < v.bfrom + v.blen; i++) bt[i][v.bbank] = 1'b1;
      if (v.err_at >= 0) et[v.err_at] = 1'b1;
    end
    // word list: write-back words first, then fill words; each waits for its bank to be free
    nw = (v.wr ? 4 : 0) + (v.rd ? 4 : 0);
    c = 1;
    last = 0;
    for (int w = 0; w < nw; w++) begin
      kk = 2'(w % 4);
      while (c < 40 && bt[c][kk]) c++;
      if (v.wr && w < 4) begin
        ev[c].wr   = 1'b1;
        ev[c].addr = {v.va, kk, 1'b0};
        ev[c].wdat = wbw[kk];
        ev[c].coff = {kk, 1'b0};
      end else begin
        ev[c].rd            = 1'b1;
        ev[c].addr          = {v.fa, kk, 1'b0};
        ev[c+RD_LAT].fwe    = 1'b1;
        ev[c+RD_LAT].foff   = {kk, 1'b0};
        ev[c+RD_LAT].fdat   = v.base + {13'd0, kk, 1'b0};
      end
      last = c;
      c++;
    end
    dn = last + 1 + (v.rd ? RD_LAT : 0);
    e = 1'b0;
    for (int i = 1; i < dn; i++)
      if ((ev[i].wr || ev[i].rd || ev[i].fwe) && et[i]) e = 1'b1;
    ev[dn].done   = 1'b1;
    ev[dn].err    = e;
    ev[0].rdy     = 1'b1;
    ev[dn+1].rdy  = 1'b1;

    cur_base = v.base;
    cur_rd   = v.rd;
    cur_wr   = v.wr;
    cur_va   = v.va;
    cur_fa   = v.fa;
    got_done = -1;
    got_err  = 1'b0;
    got_addr0 = '0;
    seen     = 1'b0;
    for (int rel = 0; rel <= dn + 1; rel++) begin
      if (rel == dn + 1) begin
        cur_rd = 1'b0;
        cur_wr = 1'b0;
      end else if (rel > 0) begin
        // the line addresses must have been captured at accept
        cur_va = 13'($urandom);
        cur_fa = 13'($urandom);
      end
      cur_busy = bt[rel];
      cur_err  = et[rel];
      tick(o);
      if (o.done && got_done < 0) begin got_done = rel; got_err = o.err; end
      if ((o.wr || o.rd) && !seen) begin seen = 1'b1; got_addr0 = o.addr; end
      check("cycle", rel, 64'(msk(o)), 64'(ev[rel]));
    end
    cur_busy = 4'd0;
    cur_err  = 1'b0;
  endtask

  initial begin
    vec_t        tbl [7];
    vec_t        v;
    out_t        o, rv;
    int          gd;
    logic        ge;
    logic [15:0] ga;
    int          r;

    //           rd wr va       fa       base      bank from len errat done err addr0
    tbl[0] = '{1, 0, 13'h0000, 13'h0123, 16'hA000, 0, 0, 0, -1,  7, 0, 16'h0918};  // fill only
    tbl[1] = '{0, 1, 13'h1FFF, 13'h0000, 16'h0000, 0, 0, 0, -1,  5, 0, 16'hFFF8};  // write-back only
    tbl[2] = '{1, 1, 13'h0456, 13'h0789, 16'hB000, 0, 0, 0, -1, 11, 0, 16'h22B0};  // evict + fill
    tbl[3] = '{1, 0, 13'h0000, 13'h0123, 16'hA000, 2, 3, 3, -1, 10, 0, 16'h0918};  // bank 2 busy 3 cycles
    tbl[4] = '{1, 0, 13'h0000, 13'h0123, 16'hA000, 0, 0, 0,  2,  7, 1, 16'h0918};  // error on 2nd read
    tbl[5] = '{1, 0, 13'h0000, 13'h1000, 16'h5000, 0, 0, 0, -1,  7, 0, 16'h8000};  // clean after error
    tbl[6] = '{0, 1, 13'h0ABC, 13'h0000, 16'h0000, 0, 1, 2, -1,  7, 0, 16'h55E0};  // bank 0 busy at start

    rv = '0;
    rv.rdy = 1'b1;
    for (int i = 0; i < RD_LAT; i++) begin hv[i] = 1'b0; ha[i] = '0; end
    wbw[0] = 16'h1111; wbw[1] = 16'h2222; wbw[2] = 16'h3333; wbw[3] = 16'h4444;
    cur_rd = 0; cur_wr = 0; cur_err = 0; cur_va = '0; cur_fa = '0; cur_busy = '0; cur_base = '0;
    bus.req_rd = 0; bus.req_wr = 0; bus.victim_addr = '0; bus.fill_addr = '0;
    bus.mem_busy = '0; bus.mem_err = 0; bus.mem_data_in = '0;

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick(o);
      check("reset_state", i, 64'(rst_view(o)), 64'(rv));
    end
    rst_n = 1'b1;
    tick(o);

    for (int i = 0; i < 7; i++) begin
      run_txn(tbl[i], 1'b0, gd, ge, ga);
      check("done_at", i, 64'(gd), 64'(tbl[i].exp_done));
      check("err", i, 64'(ge), 64'(tbl[i].exp_err));
      check("addr0", i, 64'(ga), 64'(tbl[i].exp_addr0));
    end

    // Reset while filling after a write-back, with one read already in flight.
    cur_rd = 1; cur_wr = 1; cur_va = 13'h0111; cur_fa = 13'h0222; cur_base = 16'hC000;
    for (int rel = 0; rel <= 5; rel++) begin
      tick(o);
      cur_rd = 0;
      cur_wr = 0;
    end
    @(posedge clk);
    #1;
    o = grab();
    check("rst_pre_rd", 0, {47'd0, o.rd, o.addr}, {47'd0, 1'b1, 16'h1112});
    rst_n = 1'b0;
    #1;
    check("rst_now", 0, 64'(rst_view(grab())), 64'(rv));
    for (int i = 0; i < RD_LAT; i++) hv[i] = 1'b0;
    #2;
    tick(o);
    check("rst_hold", 0, 64'(rst_view(o)), 64'(rv));
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(o);
      check("post_rst", i, {61'd0, o.fwe, o.rdy, o.done}, {61'd0, 3'b010});
    end
    v = tbl[0];
    run_txn(v, 1'b0, gd, ge, ga);
    check("rst_new_done", 0, 64'(gd), 64'd7);

    // randomized requests, busy banks and memory errors
    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(1, 3);
      v.rd   = r[0];
      v.wr   = r[1];
      v.va   = 13'($urandom);
      v.fa   = 13'($urandom);
      v.base = 16'($urandom);
      for (int k = 0; k < 4; k++) wbw[k] = 16'($urandom);
      run_txn(v, 1'b1, gd, ge, ga);
      if (($urandom_range(0, 1)) == 1) tick(o);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
